ahb_apb_bridge_gen2: RTL and testbench

Parametrised AHB-Lite slave to APB4 master bridge, the next generation of the team's AHB2APB bridge. It generalises address/data width and peripheral count, decodes onto NUM_SLV one-hot selects, honours APB wait states (pready) and converts pslverr or unmapped addresses into a two-cycle AHB ERROR response. It has one outstanding transfer, sits between the AHB interconnect and the peripheral slaves, and derives byte strobes from hsize.

---
 rtl/ahb_apb_pkg.sv | 31 +++
 rtl/apb_addr_decoder.sv | 26 ++
 rtl/ahb_apb_bridge_gen2.sv | 127 ++++++++++++
 tb/tb_ahb_apb_bridge_gen2.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge: transfer types, response codes,
// bridge FSM states and the byte-strobe helper.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCAP,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  // 2^size contiguous byte lanes starting at the lane selected by the low address bits
  function automatic logic [7:0] strbFromSize(input logic [2:0] addrLo, input logic [2:0] size);
    logic [7:0] ones;
    ones = 8'hFF >> (4'd8 - (4'd1 << size));
    return ones << addrLo;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps an AHB address onto a one-hot APB slave select; each slave owns a
// 2^DEC_LSB window starting at BASE_ADDR.
module apb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_SLV   = 4,
  parameter int unsigned       DEC_LSB   = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic [ADDR_W-1:0]  i_haddr,
  output logic [NUM_SLV-1:0] o_sel,
  output logic               o_hit
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_window;

  assign w_offset = i_haddr - BASE_ADDR;
  assign w_window = w_offset >> DEC_LSB;
  assign o_hit    = (i_haddr >= BASE_ADDR) && (w_window < ADDR_W'(NUM_SLV));
  assign o_sel    = o_hit ? (NUM_SLV'(1) << w_window[IDX_W-1:0]) : '0;

endmodule

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-Lite slave to APB4 master bridge with one outstanding transfer, wait-state
// support and a two-cycle AHB ERROR response for slave errors or bad accesses.
module ahb_apb_bridge_gen2
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SLV   = 4,
  parameter int unsigned       DEC_LSB   = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                  i_hclk,
  input  logic                  i_hresetn,
  input  logic                  i_hsel,
  input  logic                  i_hwrite,
  input  logic                  i_hready_in,
  input  logic [1:0]            i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic [ADDR_W-1:0]     i_haddr,
  input  logic [DATA_W-1:0]     i_hwdata,
  output logic [DATA_W-1:0]     o_hrdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [ADDR_W-1:0]     o_paddr,
  output logic [DATA_W-1:0]     o_pwdata,
  output logic [DATA_W/8-1:0]   o_pstrb,
  output logic [NUM_SLV-1:0]    o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  input  logic [DATA_W-1:0]     i_prdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned MAX_SIZE = $clog2(STRB_W);
  localparam logic [2:0]  LO_MASK  = 3'(STRB_W - 1);

  bridge_state_e       r_state, w_next;
  logic [NUM_SLV-1:0]  r_selOh, r_psel;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata, r_hrdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic                r_pwrite, r_penable, r_hreadyout, r_hresp;

  logic [NUM_SLV-1:0]  w_decSel, w_selNext;
  logic [STRB_W-1:0]   w_strb;
  logic                w_hit, w_take, w_err, w_newTxn;

  apb_addr_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .DEC_LSB   (DEC_LSB),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .i_haddr (i_haddr),
    .o_sel   (w_decSel),
    .o_hit   (w_hit)
  );

  // Only IDLE and ERR2 present hreadyout=1, so only they may take a new address phase
  assign w_take    = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) && i_hsel && i_hready_in &&
                     ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));
  assign w_err     = !w_hit || (i_hsize > 3'(MAX_SIZE));
  assign w_newTxn  = w_take && !w_err;
  assign w_strb    = STRB_W'(strbFromSize(i_haddr[2:0] & LO_MASK, i_hsize));
  assign w_selNext = w_newTxn ? w_decSel : r_selOh;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (!w_take)     w_next = ST_IDLE;
        else if (w_err)  w_next = ST_ERR1;
        else if (i_hwrite) w_next = ST_WCAP;
        else             w_next = ST_SETUP;
      end
      ST_WCAP:   w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (i_pready) w_next = i_pslverr ? ST_ERR1 : ST_IDLE;
      ST_ERR1:   w_next = ST_ERR2;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state     <= ST_IDLE;
      r_selOh     <= '0;
      r_psel      <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_hreadyout <= (w_next == ST_IDLE) || (w_next == ST_ERR2);
      r_hresp     <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      r_penable   <= (w_next == ST_ACCESS);
      r_psel      <= ((w_next == ST_SETUP) || (w_next == ST_ACCESS)) ? w_selNext : '0;
      if (w_newTxn) begin
        r_selOh  <= w_decSel;
        r_paddr  <= i_haddr;
        r_pwrite <= i_hwrite;
        r_pstrb  <= i_hwrite ? w_strb : '0;
      end
      if (r_state == ST_WCAP) r_pwdata <= i_hwdata;
      if ((r_state == ST_ACCESS) && i_pready && !i_pslverr && !r_pwrite) r_hrdata <= i_prdata;
    end
  end

  assign o_hrdata    = r_hrdata;
  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_pstrb     = r_pstrb;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Directed bench for ahb_apb_bridge_gen2: cycle-by-cycle checks of reset, writes,
// wait-state reads, strobes, error responses, back-to-back and mid-transfer reset.
module tb_ahb_apb_bridge_gen2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        hsel = 1'b0, hwrite = 1'b0, hreadyIn = 1'b1;
  logic [1:0]  htrans = T_IDLE;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
  logic        pready = 1'b1, pslverr = 1'b0;
  logic [31:0] hrdata, paddr, pwdata;
  logic        hreadyout, hresp, penable, pwrite;
  logic [3:0]  pstrb, psel;

  int nCompared = 0;
  int nMismatched = 0;

  ahb_apb_bridge_gen2 dut (
    .i_hclk      (hclk),
    .i_hresetn   (hresetn),
    .i_hsel      (hsel),
    .i_hwrite    (hwrite),
    .i_hready_in (hreadyIn),
    .i_htrans    (htrans),
    .i_hsize     (hsize),
    .i_haddr     (haddr),
    .i_hwdata    (hwdata),
    .o_hrdata    (hrdata),
    .o_hreadyout (hreadyout),
    .o_hresp     (hresp),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .o_pstrb     (pstrb),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .i_prdata    (prdata),
    .i_pready    (pready),
    .i_pslverr   (pslverr)
  );

  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic write, input logic [1:0] trans,
                               input logic [2:0] size, input logic [31:0] addr);
    hsel   = sel;
    hwrite = write;
    htrans = trans;
    hsize  = size;
    haddr  = addr;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, T_IDLE, 3'd0, 32'h0);
  endtask

  // Step to 1 time unit after the next rising edge; registered outputs are settled there
  task automatic cycleStep();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    // Reset values
    #3 hresetn = 1'b0;
    #4;
    checkOutput("rst_hreadyout", hreadyout, 1);
    checkOutput("rst_hresp", hresp, 0);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_pwrite", pwrite, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_pstrb", pstrb, 0);
    checkOutput("rst_hrdata", hrdata, 0);
    cycleStep();
    hresetn = 1'b1;

    // Word write to slave 2
    cycleStep();
    applyStimulus(1'b1, 1'b1, T_NONSEQ, 3'd2, 32'h8000_2004);
    checkOutput("wr_t0_hreadyout", hreadyout, 1);
    cycleStep();
    applyIdle();
    hwdata = 32'hDEAD_BEEF;
    checkOutput("wr_t1_hreadyout", hreadyout, 0);
    checkOutput("wr_t1_psel", psel, 0);
    cycleStep();
    hwdata = 32'h0;
    checkOutput("wr_t2_psel", psel, 4'b0100);
    checkOutput("wr_t2_penable", penable, 0);
    checkOutput("wr_t2_paddr", paddr, 32'h8000_2004);
    checkOutput("wr_t2_pwdata", pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_t2_pstrb", pstrb, 4'hF);
    checkOutput("wr_t2_pwrite", pwrite, 1);
    cycleStep();
    checkOutput("wr_t3_penable", penable, 1);
    checkOutput("wr_t3_psel", psel, 4'b0100);
    checkOutput("wr_t3_pwdata", pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_t3_hreadyout", hreadyout, 0);
    cycleStep();
    checkOutput("wr_t4_hreadyout", hreadyout, 1);
    checkOutput("wr_t4_hresp", hresp, 0);
    checkOutput("wr_t4_psel", psel, 0);
    checkOutput("wr_t4_penable", penable, 0);

    // Read from slave 1 with three wait states
    cycleStep();
    applyStimulus(1'b1, 1'b0, T_NONSEQ, 3'd2, 32'h8000_1010);
    pready = 1'b0;
    prdata = 32'h1234_5678;
    cycleStep();
    applyIdle();
    checkOutput("rd_t1_psel", psel, 4'b0010);
    checkOutput("rd_t1_penable", penable, 0);
    checkOutput("rd_t1_pwrite", pwrite, 0);
    checkOutput("rd_t1_pstrb", pstrb, 0);
    checkOutput("rd_t1_hreadyout", hreadyout, 0);
    cycleStep();
    checkOutput("rd_t2_penable", penable, 1);
    cycleStep();
    cycleStep();
    checkOutput("rd_t4_psel", psel, 4'b0010);
    checkOutput("rd_t4_penable", penable, 1);
    checkOutput("rd_t4_paddr", paddr, 32'h8000_1010);
    checkOutput("rd_t4_hreadyout", hreadyout, 0);
    cycleStep();
    pready = 1'b1;
    checkOutput("rd_t5_hreadyout", hreadyout, 0);
    checkOutput("rd_t5_penable", penable, 1);
    cycleStep();
    checkOutput("rd_t6_hreadyout", hreadyout, 1);
    checkOutput("rd_t6_hrdata", hrdata, 32'h1234_5678);
    checkOutput("rd_t6_hresp", hresp, 0);
    checkOutput("rd_t6_penable", penable, 0);

    // Byte write to the top lane of slave 0
    cycleStep();
    applyStimulus(1'b1, 1'b1, T_NONSEQ, 3'd0, 32'h8000_0003);
    cycleStep();
    applyIdle();
    hwdata = 32'hAA00_0000;
    cycleStep();
    checkOutput("bw_pstrb", pstrb, 4'b1000);
    checkOutput("bw_psel", psel, 4'b0001);
    checkOutput("bw_paddr", paddr, 32'h8000_0003);
    checkOutput("bw_pwdata", pwdata, 32'hAA00_0000);
    cycleStep();
    cycleStep();
    checkOutput("bw_done_hreadyout", hreadyout, 1);
    checkOutput("bw_hrdata_held", hrdata, 32'h1234_5678);

    // Unmapped address
    cycleStep();
    applyStimulus(1'b1, 1'b0, T_NONSEQ, 3'd2, 32'h8000_4000);
    cycleStep();
    applyIdle();
    checkOutput("um_err1_hreadyout", hreadyout, 0);
    checkOutput("um_err1_hresp", hresp, 1);
    checkOutput("um_err1_psel", psel, 0);
    cycleStep();
    checkOutput("um_err2_hreadyout", hreadyout, 1);
    checkOutput("um_err2_hresp", hresp, 1);
    checkOutput("um_err2_psel", psel, 0);
    cycleStep();
    checkOutput("um_idle_hresp", hresp, 0);
    checkOutput("um_idle_hreadyout", hreadyout, 1);

    // Oversized hsize, then a read accepted during ERR2
    cycleStep();
    applyStimulus(1'b1, 1'b1, T_NONSEQ, 3'd3, 32'h8000_0000);
    cycleStep();
    applyIdle();
    checkOutput("sz_err1_hresp", hresp, 1);
    checkOutput("sz_err1_hreadyout", hreadyout, 0);
    checkOutput("sz_err1_psel", psel, 0);
    cycleStep();
    checkOutput("sz_err2_hresp", hresp, 1);
    checkOutput("sz_err2_hreadyout", hreadyout, 1);
    applyStimulus(1'b1, 1'b0, T_NONSEQ, 3'd2, 32'h8000_3000);
    prdata = 32'hCAFE_0001;
    cycleStep();
    applyIdle();
    checkOutput("e2b_setup_psel", psel, 4'b1000);
    checkOutput("e2b_setup_hresp", hresp, 0);
    checkOutput("e2b_setup_hreadyout", hreadyout, 0);
    checkOutput("e2b_setup_paddr", paddr, 32'h8000_3000);
    cycleStep();
    cycleStep();
    checkOutput("e2b_done_hreadyout", hreadyout, 1);
    checkOutput("e2b_done_hrdata", hrdata, 32'hCAFE_0001);

    // Slave error on a read
    cycleStep();
    applyStimulus(1'b1, 1'b0, T_NONSEQ, 3'd2, 32'h8000_0000);
    prdata = 32'hBAD0_0000;
    cycleStep();
    applyIdle();
    pslverr = 1'b1;
    checkOutput("se_setup_psel", psel, 4'b0001);
    cycleStep();
    checkOutput("se_access_penable", penable, 1);
    cycleStep();
    pslverr = 1'b0;
    checkOutput("se_err1_hreadyout", hreadyout, 0);
    checkOutput("se_err1_hresp", hresp, 1);
    checkOutput("se_err1_psel", psel, 0);
    checkOutput("se_err1_penable", penable, 0);
    cycleStep();
    checkOutput("se_err2_hreadyout", hreadyout, 1);
    checkOutput("se_err2_hresp", hresp, 1);
    checkOutput("se_err2_hrdata", hrdata, 32'hCAFE_0001);
    cycleStep();

    // Write followed by a read issued in the completion cycle
    cycleStep();
    applyStimulus(1'b1, 1'b1, T_NONSEQ, 3'd2, 32'h8000_1008);
    cycleStep();
    applyIdle();
    hwdata = 32'h0102_0304;
    cycleStep();
    checkOutput("bb_wr_pwdata", pwdata, 32'h0102_0304);
    checkOutput("bb_wr_psel", psel, 4'b0010);
    cycleStep();
    cycleStep();
    checkOutput("bb_wr_done_hreadyout", hreadyout, 1);
    applyStimulus(1'b1, 1'b0, T_SEQ, 3'd2, 32'h8000_2000);
    prdata = 32'h55AA_55AA;
    cycleStep();
    applyIdle();
    checkOutput("bb_rd_psel", psel, 4'b0100);
    checkOutput("bb_rd_pwrite", pwrite, 0);
    checkOutput("bb_rd_paddr", paddr, 32'h8000_2000);
    checkOutput("bb_rd_pstrb", pstrb, 0);
    cycleStep();
    cycleStep();
    checkOutput("bb_rd_hreadyout", hreadyout, 1);
    checkOutput("bb_rd_hrdata", hrdata, 32'h55AA_55AA);

    // Reset asserted while ACCESS is stalled
    cycleStep();
    applyStimulus(1'b1, 1'b0, T_NONSEQ, 3'd2, 32'h8000_0004);
    pready = 1'b0;
    cycleStep();
    applyIdle();
    cycleStep();
    checkOutput("ar_access_penable", penable, 1);
    checkOutput("ar_access_psel", psel, 4'b0001);
    #2 hresetn = 1'b0;
    #1;
    checkOutput("ar_psel", psel, 0);
    checkOutput("ar_penable", penable, 0);
    checkOutput("ar_hreadyout", hreadyout, 1);
    checkOutput("ar_paddr", paddr, 0);
    checkOutput("ar_hrdata", hrdata, 0);
    cycleStep();
    hresetn = 1'b1;
    pready = 1'b1;
    cycleStep();
    checkOutput("ar_after_psel", psel, 0);
    checkOutput("ar_after_hreadyout", hreadyout, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
